// File: rtl/aes_decipher_round_ctrl.sv
// Round sequencer for the AES decipher datapath. It holds the cipher state and steps the datapath through INIT, MAIN and FINAL rounds.
// Define AES_DECIPHER_CTRL_ABORT_EN to add an abort input that cancels an operation in flight.
module aes_decipher_round_ctrl #(
    parameter int AES128_ROUNDS = 10,
    parameter int AES256_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         keylen,
    input  logic         next,
`ifdef AES_DECIPHER_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] block,
    output logic         ready,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [1:0]   round_type,
    output logic [127:0] state,
    input  logic [127:0] state_new,
    output logic [127:0] result,
    output logic         result_valid
);

    localparam logic [3:0] N128 = 4'(AES128_ROUNDS);
    localparam logic [3:0] N256 = 4'(AES256_ROUNDS);

    localparam logic [1:0] RT_INIT  = 2'd0;
    localparam logic [1:0] RT_MAIN  = 2'd1;
    localparam logic [1:0] RT_FINAL = 2'd2;
    localparam logic [1:0] RT_NOP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_MAIN,
        ST_FINAL
    } ctrl_state_e;

    ctrl_state_e fsm;
    logic [3:0]  round_ctr;
    logic        keylen_reg;
    logic        abort_req;

`ifdef AES_DECIPHER_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The key memory is addressed straight from the round counter, so it needs no extra wait state.
    assign round = round_ctr;

    // round_key goes straight to the datapath. keylen_reg is kept only for visibility.
    logic unused_inputs;
    assign unused_inputs = ^{round_key, keylen_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm          <= ST_IDLE;
            ready        <= 1'b1;
            result_valid <= 1'b0;
            state        <= '0;
            result       <= '0;
            round_ctr    <= '0;
            round_type   <= RT_NOP;
            keylen_reg   <= 1'b0;
        end else if (abort_req && fsm != ST_IDLE) begin
            // An abort discards the state in flight. The last valid result stays in place.
            fsm        <= ST_IDLE;
            state      <= '0;
            round_ctr  <= '0;
            ready      <= 1'b1;
            round_type <= RT_NOP;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (next) begin
                        state        <= block;
                        keylen_reg   <= keylen;
                        round_ctr    <= keylen ? N256 : N128;
                        result_valid <= 1'b0;
                        ready        <= 1'b0;
                        round_type   <= RT_INIT;
                        fsm          <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    state      <= state_new;
                    round_ctr  <= round_ctr - 4'd1;
                    round_type <= RT_MAIN;
                    fsm        <= ST_MAIN;
                end
                ST_MAIN: begin
                    state     <= state_new;
                    round_ctr <= round_ctr - 4'd1;
                    if (round_ctr == 4'd1) begin
                        round_type <= RT_FINAL;
                        fsm        <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    state        <= state_new;
                    result       <= state_new;
                    result_valid <= 1'b1;
                    ready        <= 1'b1;
                    round_type   <= RT_NOP;
                    fsm          <= ST_IDLE;
                end
                default: begin
                    fsm <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
